// File: rtl/dmem_ctrl.sv
// Data-memory controller: DEPTH x 32 RAM, byte writes, LATENCY wait states.
// Define DMEM_ZEROIZE_EN to sweep the RAM to zero after every reset.
module dmem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mreq,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [3:0]        w_mem,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              mres,
    output logic              busy
);

`ifdef DMEM_ZEROIZE_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_e;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
`endif

    localparam logic [3:0] LAT_M1 =
        (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam bit ZERO_LAT = (LATENCY == 0);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [3:0]        req_we_q;
    logic [31:0]       req_data_q;
    logic [31:0]       load_q;
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_we;
    logic [31:0]       wr_data;
    logic [31:0]       merged;
    logic [31:0]       mem [DEPTH];

`ifdef DMEM_ZEROIZE_EN
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_we;
`endif

    // With zero latency the commit happens on the accept edge itself.
    always_comb begin
        wr_addr = req_addr_q;
        wr_we   = req_we_q;
        wr_data = req_data_q;
        if (state_q == IDLE) begin
            wr_addr = addr_mem;
            wr_we   = w_mem;
            wr_data = store_data;
        end
        merged = mem[wr_addr];
        for (int b = 0; b < 4; b++) begin
            if (wr_we[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
`ifdef DMEM_ZEROIZE_EN
        clr_we     = 1'b0;
        clr_addr_d = clr_addr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mreq) begin
                    cnt_d = LAT_M1;
                    if (ZERO_LAT) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
`ifdef DMEM_ZEROIZE_EN
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
`ifdef DMEM_ZEROIZE_EN
            state_q    <= CLEAR;
            clr_addr_q <= '0;
`else
            state_q <= IDLE;
`endif
            cnt_q      <= 4'd0;
            load_q     <= 32'h0;
            req_addr_q <= '0;
            req_we_q   <= 4'd0;
            req_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef DMEM_ZEROIZE_EN
            clr_addr_q <= clr_addr_d;
`endif
            if (state_q == IDLE && mreq) begin
                req_addr_q <= addr_mem;
                req_we_q   <= w_mem;
                req_data_q <= store_data;
            end
            if (commit) load_q <= merged;
        end
    end

    // Reset wins over a commit on the same edge: no write lands.
    always_ff @(posedge clk) begin
        if (resetn && commit) begin
            mem[wr_addr] <= merged;
        end
`ifdef DMEM_ZEROIZE_EN
        if (resetn && clr_we) begin
            mem[clr_addr_q] <= 32'h0;
        end
`endif
    end

    assign load_data = load_q;
    assign mres      = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: four instances (LATENCY 1, 0, 15, 3) against a
// schedule-based model, plus directed literal checks.
module tb_dmem_ctrl;

    localparam int N   = 4;
    localparam int DEP = 256;
    localparam int LAT [N] = '{1, 0, 15, 3};
`ifdef DMEM_ZEROIZE_EN
    localparam bit ZER = 1'b1;
`else
    localparam bit ZER = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn [N];
    logic        mreq   [N];
    logic [7:0]  addr   [N];
    logic [3:0]  wm     [N];
    logic [31:0] sd     [N];
    logic [31:0] ld     [N];
    logic        mres   [N];
    logic        busy   [N];

    dmem_ctrl #(.ADDR_W(8), .DEPTH(DEP), .LATENCY(1)) u0 (
        .clk(clk), .resetn(resetn[0]), .mreq(mreq[0]), .addr_mem(addr[0]),
        .w_mem(wm[0]), .store_data(sd[0]), .load_data(ld[0]),
        .mres(mres[0]), .busy(busy[0]));
    dmem_ctrl #(.ADDR_W(8), .DEPTH(DEP), .LATENCY(0)) u1 (
        .clk(clk), .resetn(resetn[1]), .mreq(mreq[1]), .addr_mem(addr[1]),
        .w_mem(wm[1]), .store_data(sd[1]), .load_data(ld[1]),
        .mres(mres[1]), .busy(busy[1]));
    dmem_ctrl #(.ADDR_W(8), .DEPTH(DEP), .LATENCY(15)) u2 (
        .clk(clk), .resetn(resetn[2]), .mreq(mreq[2]), .addr_mem(addr[2]),
        .w_mem(wm[2]), .store_data(sd[2]), .load_data(ld[2]),
        .mres(mres[2]), .busy(busy[2]));
    dmem_ctrl #(.ADDR_W(8), .DEPTH(DEP), .LATENCY(3)) u3 (
        .clk(clk), .resetn(resetn[3]), .mreq(mreq[3]), .addr_mem(addr[3]),
        .w_mem(wm[3]), .store_data(sd[3]), .load_data(ld[3]),
        .mres(mres[3]), .busy(busy[3]));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, d, $time, act, exp);
        end
    endtask

    // Model: each request owns the edges [accept, accept+LAT]; mres in the
    // cycle after accept+LAT; next accept no earlier than accept+LAT+2.
    int          cyc = 0;
    bit          started  [N];
    bit          pend     [N];
    int          lo       [N];
    int          hi       [N];
    int          resp     [N];
    int          mres_at  [N];
    logic [31:0] exp_ld   [N];
    bit          ld_known [N];
    logic [31:0] mm       [N][DEP];
    bit          known    [N][DEP];
    logic [7:0]  ra       [N];
    logic [3:0]  rw       [N];
    logic [31:0] rdat     [N];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < N; d++) begin
            if (!resetn[d]) begin
                started[d]  = 1'b1;
                pend[d]     = 1'b0;
                exp_ld[d]   = 32'h0;
                ld_known[d] = 1'b1;
                mres_at[d]  = -100;
                if (ZER) begin
                    lo[d] = cyc;
                    hi[d] = cyc + DEP - 1;
                    for (int k = 0; k < DEP; k++) begin
                        mm[d][k]    = 32'h0;
                        known[d][k] = 1'b1;
                    end
                end else begin
                    lo[d] = cyc + 1;
                    hi[d] = cyc - 1;
                end
            end else if (started[d]) begin
                if (!pend[d] && cyc >= hi[d] + 2 && mreq[d]) begin
                    pend[d] = 1'b1;
                    lo[d]   = cyc;
                    hi[d]   = cyc + LAT[d];
                    resp[d] = cyc + LAT[d];
                    ra[d]   = addr[d];
                    rw[d]   = wm[d];
                    rdat[d] = sd[d];
                end
                if (pend[d] && cyc == resp[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (rw[d][b]) mm[d][ra[d]][8*b +: 8] = rdat[d][8*b +: 8];
                    end
                    if (rw[d] == 4'hF) known[d][ra[d]] = 1'b1;
                    exp_ld[d]   = mm[d][ra[d]];
                    ld_known[d] = known[d][ra[d]];
                    mres_at[d]  = cyc;
                    pend[d]     = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (started[d]) begin
                chk("mres", d, {31'b0, mres[d]}, {31'b0, cyc == mres_at[d]});
                chk("busy", d, {31'b0, busy[d]},
                    {31'b0, (cyc >= lo[d] && cyc <= hi[d])});
                if (ld_known[d]) chk("load_data", d, ld[d], exp_ld[d]);
            end
        end
    end

    // Called #1 after an edge; returns #1 after the RESP->IDLE edge.
    task automatic do_req(input int d, input logic [7:0] a, input logic [3:0] we,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd);
        addr[d] = a;
        wm[d]   = we;
        sd[d]   = wd;
        mreq[d] = 1'b1;
        lat     = 0;
        while (lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            if (mres[d]) break;
        end
        mreq[d] = 1'b0;
        rd      = ld[d];
        if (!mres[d]) begin
            tests++;
            fails++;
            $display("FAIL timeout dut%0d no mres within %0d edges", d, lat);
        end
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [31:0] r;
    int          cnt;

    initial begin
        for (int d = 0; d < N; d++) begin
            resetn[d] = 1'b0;
            mreq[d]   = 1'b0;
            addr[d]   = 8'h0;
            wm[d]     = 4'h0;
            sd[d]     = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_load", 0, ld[0], 32'h0);
        chk("reset_busy", 1, {31'b0, busy[1]}, {31'b0, ZER});
        for (int d = 0; d < N; d++) resetn[d] = 1'b1;
`ifdef DMEM_ZEROIZE_EN
        repeat (DEP + 2) @(posedge clk);
        #1;
`endif

        do_req(0, 8'h10, 4'hF, 32'hDEADBEEF, lat, r);
        chk("t1_wr_lat", 0, lat, 2);
        chk("t1_wr_data", 0, r, 32'hDEADBEEF);
        do_req(0, 8'h10, 4'h0, 32'h0, lat, r);
        chk("t1_rd_lat", 0, lat, 2);
        chk("t1_rd_data", 0, r, 32'hDEADBEEF);

        do_req(0, 8'h20, 4'hF, 32'h11223344, lat, r);
        do_req(0, 8'h20, 4'b0100, 32'h00AA0000, lat, r);
        chk("t2_merge_wr", 0, r, 32'h11AA3344);
        do_req(0, 8'h20, 4'h0, 32'hFFFFFFFF, lat, r);
        chk("t2_merge_rd", 0, r, 32'h11AA3344);

        do_req(1, 8'h05, 4'hF, 32'h12345678, lat, r);
        do_req(1, 8'h05, 4'h0, 32'h0, lat, r);
        chk("t3_lat0", 1, lat, 1);
        chk("t3_lat0_data", 1, r, 32'h12345678);
        do_req(2, 8'h07, 4'hF, 32'hA5A5C3C3, lat, r);
        do_req(2, 8'h07, 4'h0, 32'h0, lat, r);
        chk("t3_lat15", 2, lat, 16);
        chk("t3_lat15_data", 2, r, 32'hA5A5C3C3);

        do_req(3, 8'h40, 4'hF, 32'h0, lat, r);
        addr[3] = 8'h40;
        wm[3]   = 4'hF;
        sd[3]   = 32'h55AA55AA;
        mreq[3] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mreq[3] = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (mres[3]) cnt++;
        end
        chk("t4_one_pulse", 3, cnt, 1);
        do_req(3, 8'h40, 4'h0, 32'h0, lat, r);
        chk("t4_committed", 3, r, 32'h55AA55AA);

        do_req(2, 8'h30, 4'hF, 32'h0, lat, r);
        addr[2] = 8'h30;
        wm[2]   = 4'hF;
        sd[2]   = 32'hCAFEF00D;
        mreq[2] = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        resetn[2] = 1'b0;
        mreq[2]   = 1'b0;
        @(posedge clk);
        #1;
        resetn[2] = 1'b1;
        cnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (mres[2]) cnt++;
        end
        chk("t5_no_mres", 2, cnt, 0);
`ifdef DMEM_ZEROIZE_EN
        repeat (DEP + 2) @(posedge clk);
        #1;
`endif
        do_req(2, 8'h30, 4'h0, 32'h0, lat, r);
        chk("t5_not_written", 2, r, 32'h0);

`ifdef DMEM_ZEROIZE_EN
        resetn[0] = 1'b0;
        @(posedge clk);
        #1;
        resetn[0] = 1'b1;
        do_req(0, 8'hFF, 4'h0, 32'h0, lat, r);
        chk("t6_sweep_lat", 0, lat, 258);
        chk("t6_cleared", 0, r, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
